// File: rtl/pulse_cdc_pkg.sv
// rtl/pulse_cdc_pkg.sv - shared state type and default sizing for the CDC pulse sender
package pulse_cdc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } state_t;

  localparam int CNT_W_DEF       = 4;
  localparam int TIMEOUT_CYC_DEF = 64;

endpackage

// File: rtl/sat_updown_cnt.sv
// rtl/sat_updown_cnt.sv - saturating up/down event counter with sticky overflow flag
module sat_updown_cnt import pulse_cdc_pkg::*; #(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         ovf
);

  localparam logic [W-1:0] MAX = '1;

  logic drop;

  // A simultaneous inc/dec nets to zero, so it can never overflow.
  assign drop = inc && !dec && (count == MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (inc && !dec && !drop)
        count <= count + W'(1);
      else if (dec && !inc && (count != '0))
        count <= count - W'(1);

      if (drop)
        ovf <= 1'b1;
      else if (clr)
        ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/pulse_sender.sv
// rtl/pulse_sender.sv - clka-side event queue and return-to-zero pulse handshake
// Optional acknowledge timeout enabled by PULSE_SENDER_TIMEOUT_EN.
module pulse_sender import pulse_cdc_pkg::*; #(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clka,
  input  logic             rsta,
  input  logic             event_i,
  input  logic             ack_i,
  input  logic             clr_i,
  output logic             pulse_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             busy_o,
  output logic             ovf_o,
  output logic             to_err_o
);

  state_t state;
  logic   ack_q;
  logic   issue;
  logic   ack_rise;

  // A new event can issue in the same cycle it arrives, even with an empty queue.
  assign issue    = (state == IDLE) && ((pending_o != '0) || event_i);
  // Only a rise observed while in WAIT_HI counts; an ack already high is stale.
  assign ack_rise = ack_i && !ack_q;

  sat_updown_cnt #(.W(CNT_W)) u_pending (
    .clk   (clka),
    .rst_n (rsta),
    .inc   (event_i),
    .dec   (issue),
    .clr   (clr_i),
    .count (pending_o),
    .ovf   (ovf_o)
  );

`ifdef PULSE_SENDER_TIMEOUT_EN
  localparam int              TO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  assign to_hit = (to_cnt == TO_LAST);
`else
  assign to_err_o = 1'b0;
`endif

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      state   <= IDLE;
      pulse_o <= 1'b0;
      busy_o  <= 1'b0;
      ack_q   <= 1'b0;
`ifdef PULSE_SENDER_TIMEOUT_EN
      to_cnt   <= '0;
      to_err_o <= 1'b0;
`endif
    end else begin
      ack_q   <= ack_i;
      pulse_o <= 1'b0;
`ifdef PULSE_SENDER_TIMEOUT_EN
      // Zero on every state change; the wait branches override to keep counting.
      to_cnt <= '0;
      if (clr_i)
        to_err_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (issue) begin
            state   <= WAIT_HI;
            pulse_o <= 1'b1;
            busy_o  <= 1'b1;
          end
        end
        WAIT_HI: begin
          if (ack_rise) begin
            state <= WAIT_LO;
          end
`ifdef PULSE_SENDER_TIMEOUT_EN
          else if (to_hit) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            to_err_o <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end
        WAIT_LO: begin
          if (!ack_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
`ifdef PULSE_SENDER_TIMEOUT_EN
          else if (to_hit) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            to_err_o <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_sender.sv
// tb/tb_pulse_sender.sv - directed bench with a behavioural queue/handshake model, two counter widths
module tb_pulse_sender;

  localparam int TO = 8;

  logic       clka = 1'b0;
  logic       rsta = 1'b0;
  logic       ev   = 1'b0;
  logic       ack  = 1'b0;
  logic       clr  = 1'b0;

  logic       pulse_a, busy_a, ovf_a, toerr_a;
  logic [3:0] pend_a;
  logic       pulse_b, busy_b, ovf_b, toerr_b;
  logic [1:0] pend_b;

  pulse_sender #(.CNT_W(4), .TIMEOUT_CYC(TO)) dut_a (
    .clka(clka), .rsta(rsta), .event_i(ev), .ack_i(ack), .clr_i(clr),
    .pulse_o(pulse_a), .pending_o(pend_a), .busy_o(busy_a), .ovf_o(ovf_a), .to_err_o(toerr_a)
  );

  pulse_sender #(.CNT_W(2), .TIMEOUT_CYC(TO)) dut_b (
    .clka(clka), .rsta(rsta), .event_i(ev), .ack_i(ack), .clr_i(clr),
    .pulse_o(pulse_b), .pending_o(pend_b), .busy_o(busy_b), .ovf_o(ovf_b), .to_err_o(toerr_b)
  );

  always #5 clka = ~clka;

  int vectors = 0;
  int fails   = 0;
  bit chk_en  = 1'b0;

  // Model: instance 0 is CNT_W=4 (queue limit 15), instance 1 is CNT_W=2 (limit 3).
  int m_max   [2] = '{15, 3};
  int m_pend  [2] = '{0, 0};
  int m_age   [2] = '{0, 0};
  bit m_hs    [2] = '{0, 0};
  bit m_gothi [2] = '{0, 0};
  bit m_pulse [2] = '{0, 0};
  bit m_ovf   [2] = '{0, 0};
  bit m_toerr [2] = '{0, 0};
  bit m_prev_ack  = 1'b0;

  int cnt_pulse = 0;
  int cnt_busy  = 0;
  int peak      = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input int i, input bit rise);
    bit issue;
    bit ovf_set;
    bit to_set;
    int np;
    issue   = !m_hs[i] && (m_pend[i] > 0 || ev);
    np      = m_pend[i] + (ev ? 1 : 0) - (issue ? 1 : 0);
    ovf_set = 1'b0;
    to_set  = 1'b0;
    if (np > m_max[i]) begin
      np      = m_max[i];
      ovf_set = 1'b1;
    end
    if (issue) begin
      m_hs[i]    = 1'b1;
      m_gothi[i] = 1'b0;
      m_age[i]   = 0;
    end else if (m_hs[i]) begin
      if (!m_gothi[i] && rise) begin
        m_gothi[i] = 1'b1;
        m_age[i]   = 0;
      end else if (m_gothi[i] && !ack) begin
        m_hs[i] = 1'b0;
      end
`ifdef PULSE_SENDER_TIMEOUT_EN
      else if (m_age[i] == TO - 1) begin
        m_hs[i] = 1'b0;
        to_set  = 1'b1;
      end else begin
        m_age[i]++;
      end
`endif
    end
    m_pulse[i] = issue;
    m_pend[i]  = np;
    m_ovf[i]   = ovf_set || (m_ovf[i] && !clr);
    m_toerr[i] = to_set || (m_toerr[i] && !clr);
  endtask

  always @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      for (int i = 0; i < 2; i++) begin
        m_pend[i] = 0; m_age[i] = 0; m_hs[i] = 0; m_gothi[i] = 0;
        m_pulse[i] = 0; m_ovf[i] = 0; m_toerr[i] = 0;
      end
      m_prev_ack = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) model_step(i, ack && !m_prev_ack);
      m_prev_ack = ack;
    end
  end

  always @(negedge clka) begin
    if (chk_en) begin
      check("pulse_a", pulse_a, m_pulse[0]);
      check("pend_a",  pend_a,  m_pend[0]);
      check("busy_a",  busy_a,  m_hs[0]);
      check("ovf_a",   ovf_a,   m_ovf[0]);
      check("toerr_a", toerr_a, m_toerr[0]);
      check("pulse_b", pulse_b, m_pulse[1]);
      check("pend_b",  pend_b,  m_pend[1]);
      check("busy_b",  busy_b,  m_hs[1]);
      check("ovf_b",   ovf_b,   m_ovf[1]);
      check("toerr_b", toerr_b, m_toerr[1]);
      if (pulse_a) cnt_pulse++;
      if (busy_a) cnt_busy++;
      if (int'(pend_a) > peak) peak = pend_a;
    end
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int t = 0; t < n; t++) tick();
  endtask

  task automatic wait_pulse(input string name);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      tick();
      if (pulse_a) ok = 1'b1;
    end
    check(name, ok, 1);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40 && (busy_a || busy_b || pend_a != 0 || pend_b != 0); k++) begin
      ack = 1'b1; ticks(2);
      ack = 1'b0; ticks(2);
    end
    check(name, int'(busy_a || busy_b || pend_a != 0 || pend_b != 0), 0);
  endtask

  task automatic clear_counts();
    cnt_pulse = 0;
    cnt_busy  = 0;
    peak      = 0;
  endtask

  initial begin
    ticks(2);
    chk_en = 1'b1;
    check("rst_pulse", pulse_a, 0);
    check("rst_pend",  pend_a,  0);
    check("rst_busy",  busy_a,  0);
    check("rst_ovf",   ovf_a,   0);
    check("rst_toerr", toerr_a, 0);
    rsta = 1'b1;
    ticks(2);

    // Single event, ack rises 4 cycles after the pulse and falls 4 later.
    clear_counts();
    ev = 1'b1; tick(); ev = 1'b0;
    check("t1_pulse_now", pulse_a, 1);
    check("t1_pend_now",  pend_a,  0);
    ticks(4); ack = 1'b1;
    ticks(4); ack = 1'b0;
    ticks(3);
    check("t1_pulses", cnt_pulse, 1);
    check("t1_busy",   cnt_busy,  9);
    check("t1_peak",   peak,      0);

    // Five back-to-back events, 3-cycle handshake phases.
    clear_counts();
    ev = 1'b1; ticks(5); ev = 1'b0;
    check("t2_pend_a", pend_a, 4);
    check("t2_pend_b", pend_b, 3);
    check("t2_ovf_b",  ovf_b,  1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) wait_pulse("t2_pulse_wait");
      ticks(2); ack = 1'b1;
      ticks(3); ack = 1'b0;
    end
    ticks(3);
    check("t2_pulses", cnt_pulse, 5);
    check("t2_peak",   peak,      4);
    check("t2_pend_end", pend_a,  0);
    check("t2_busy_end", busy_a,  0);
    clr = 1'b1; tick(); clr = 1'b0;
    check("t2_ovf_b_clr", ovf_b, 0);

    // Saturation with ack held low; clear keeps the queue; set beats clear.
    ev = 1'b1; ticks(6); ev = 1'b0;
    check("t3_pend_b", pend_b, 3);
    check("t3_ovf_b",  ovf_b,  1);
    check("t3_pend_a", pend_a, 5);
    check("t3_ovf_a",  ovf_a,  0);
    clr = 1'b1; tick(); clr = 1'b0;
    check("t3_clr_ovf_b",  ovf_b,  0);
    check("t3_clr_pend_b", pend_b, 3);
    ev = 1'b1; clr = 1'b1; tick(); ev = 1'b0; clr = 1'b0;
    check("t3_setwins_ovf_b", ovf_b, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    drain("t3_drain");

    // Stale high ack: ignored in IDLE, needs fall then rise in WAIT_HI.
    clr = 1'b1; tick(); clr = 1'b0;
    ack = 1'b1; ticks(3);
    check("t4_idle_ack_hi", busy_a, 0);
    ev = 1'b1; tick(); ev = 1'b0;
    check("t4_pulse", pulse_a, 1);
    ticks(3);
    check("t4_stuck_hi", busy_a, 1);
    ack = 1'b0; ticks(2);
    check("t4_still_wait", busy_a, 1);
    ack = 1'b1; tick();
    ack = 1'b0; tick();
    check("t4_done", busy_a, 0);

    // Reset while in WAIT_LO with two events queued.
    ev = 1'b1; ticks(3); ev = 1'b0;
    ack = 1'b1; tick();
    check("t5_pend_pre", pend_a, 2);
    check("t5_busy_pre", busy_a, 1);
    #2 rsta = 1'b0;
    #1;
    check("t5_rst_pulse", pulse_a, 0);
    check("t5_rst_pend",  pend_a,  0);
    check("t5_rst_busy",  busy_a,  0);
    check("t5_rst_ovf",   ovf_a,   0);
    tick();
    rsta = 1'b1; ack = 1'b0;
    clear_counts();
    ticks(10);
    check("t5_no_pulse", cnt_pulse, 0);
    check("t5_pend_post", pend_a, 0);

`ifdef PULSE_SENDER_TIMEOUT_EN
    // Ack stuck low: timeout after TO cycles, queued event then issues.
    ev = 1'b1; ticks(2); ev = 1'b0;
    ticks(6);
    check("t6_no_err_yet", toerr_a, 0);
    check("t6_busy_yet",   busy_a,  1);
    tick();
    check("t6_err",      toerr_a, 1);
    check("t6_idle",     busy_a,  0);
    check("t6_pend_kept", pend_a, 1);
    tick();
    check("t6_next_pulse", pulse_a, 1);
    drain("t6_drain");
    clr = 1'b1; tick(); clr = 1'b0;
    check("t6_err_clr", toerr_a, 0);
`endif

    ticks(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
